// File: rtl/b01_out_collector.sv
// b01_out_collector: packs b01 serial outp/overflw samples LSB-first into tagged words and buffers them in a valid/ready FIFO.
// Define B01_COLLECT_PARITY_EN to store and present per-word parity on word_par.
module b01_out_collector #(
   parameter int WORD_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         outp,
   input  logic                         overflw,
   input  logic                         sample_en,
   input  logic                         flush,
   output logic [WORD_W-1:0]            word_data,
   output logic                         word_ovf,
   output logic [$clog2(WORD_W+1)-1:0]  word_len,
   output logic                         word_valid,
   input  logic                         word_ready,
   output logic                         fifo_full,
   output logic [7:0]                   drop_cnt
`ifdef B01_COLLECT_PARITY_EN
   ,
   output logic                         word_par
`endif
);
   localparam int LW = $clog2(WORD_W+1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH+1);
`ifdef B01_COLLECT_PARITY_EN
   localparam int EW = WORD_W + LW + 2;
`else
   localparam int EW = WORD_W + LW + 1;
`endif
   logic [WORD_W-1:0] sh, nsh;
   logic [LW-1:0]     bc, nbc;
   logic              ov, nov, push, pop, accept;
   logic [AW-1:0]     wp, rp, rp_nx;
   logic [CW-1:0]     cnt, rem, cnt_nx;
   logic [EW-1:0]     mem [FIFO_DEPTH];
   logic [EW-1:0]     entry, head;
   // nsh/nbc/nov include a same-cycle sample so flush sees the effective word
   always_comb begin
      nsh    = sample_en ? sh | (WORD_W'(outp) << bc) : sh;
      nbc    = bc + LW'(sample_en);
      nov    = ov | (sample_en & overflw);
      push   = (sample_en && bc == LW'(WORD_W-1)) || (flush && nbc != '0);
      pop    = word_ready && cnt != '0;
      rem    = cnt - CW'(pop);
      accept = push && rem != CW'(FIFO_DEPTH);
      cnt_nx = rem + CW'(accept);
      rp_nx  = rp + AW'(pop);
`ifdef B01_COLLECT_PARITY_EN
      entry  = {^nsh, nov, nbc, nsh};
`else
      entry  = {nov, nbc, nsh};
`endif
   end
   // head mirrors the entry at the next read pointer; a word pushed into an emptying FIFO is forwarded directly
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sh       <= '0;
         bc       <= '0;
         ov       <= 1'b0;
         wp       <= '0;
         rp       <= '0;
         cnt      <= '0;
         head     <= '0;
         drop_cnt <= '0;
      end else begin
         sh   <= push ? '0 : nsh;
         bc   <= push ? '0 : nbc;
         ov   <= push ? 1'b0 : nov;
         wp   <= wp + AW'(accept);
         rp   <= rp_nx;
         cnt  <= cnt_nx;
         head <= cnt_nx == '0 ? '0 : rem == '0 ? entry : mem[rp_nx];
         if (push && !accept && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
   end
   always_ff @(posedge clock) begin
      if (accept) mem[wp] <= entry;
   end
   assign word_data  = head[WORD_W-1:0];
   assign word_len   = head[WORD_W +: LW];
   assign word_ovf   = head[WORD_W+LW];
   assign word_valid = cnt != '0;
   assign fifo_full  = cnt == CW'(FIFO_DEPTH);
`ifdef B01_COLLECT_PARITY_EN
   assign word_par   = head[WORD_W+LW+1];
`endif
endmodule

// File: tb/tb_b01_out_collector.sv
// tb_b01_out_collector: scoreboard bench for b01_out_collector (WORD_W=8, FIFO_DEPTH=4).
module tb_b01_out_collector;
   logic       clock = 1'b0, reset = 1'b0;
   logic       outp = 1'b0, overflw = 1'b0, sample_en = 1'b0, flush = 1'b0, word_ready = 1'b0;
   logic [7:0] word_data;
   logic       word_ovf, word_valid, fifo_full;
   logic [3:0] word_len;
   logic [7:0] drop_cnt;
`ifdef B01_COLLECT_PARITY_EN
   logic       word_par;
`endif
   typedef struct packed {logic ovf; logic [3:0] len; logic [7:0] data;} ent_t;
   ent_t q[$];
   logic [7:0] m_sh = '0;
   int         m_bc = 0, m_drop = 0;
   logic       m_ov = 1'b0;
   int         checks = 0, failures = 0;

   b01_out_collector #(.WORD_W(8), .FIFO_DEPTH(4)) dut (
      .clock(clock), .reset(reset), .outp(outp), .overflw(overflw), .sample_en(sample_en),
      .flush(flush), .word_data(word_data), .word_ovf(word_ovf), .word_len(word_len),
      .word_valid(word_valid), .word_ready(word_ready), .fifo_full(fifo_full), .drop_cnt(drop_cnt)
`ifdef B01_COLLECT_PARITY_EN
      , .word_par(word_par)
`endif
   );

   always #5 clock = ~clock;

   // one clock cycle of stimulus; the model pops/pushes the scoreboard as the DUT should
   task automatic cyc(input logic s, input logic b, input logic o, input logic f, input logic r);
      int eff;
      sample_en = s; outp = b; overflw = o; flush = f; word_ready = r;
      if (r && q.size() != 0) void'(q.pop_front());
      eff = m_bc + (s ? 1 : 0);
      if (s) begin
         m_sh[m_bc] = b;
         m_ov = m_ov | o;
      end
      m_bc = eff;
      if ((s && eff == 8) || (f && eff != 0)) begin
         if (q.size() < 4) q.push_back('{m_ov, 4'(eff), m_sh});
         else if (m_drop < 255) m_drop++;
         m_sh = '0; m_bc = 0; m_ov = 1'b0;
      end
      @(posedge clock); #1;
      sample_en = 1'b0; outp = 1'b0; overflw = 1'b0; flush = 1'b0; word_ready = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] d, input logic [7:0] o);
      for (int i = 0; i < 8; i++) cyc(1'b1, d[i], o[i], 1'b0, 1'b0);
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if ({word_valid, word_data, word_len, word_ovf, fifo_full, drop_cnt} !== 23'd0) begin
         failures++;
         $display("FAIL reset_outputs got v=%0b d=%h l=%0d o=%0b f=%0b drop=%0d required all 0",
                  word_valid, word_data, word_len, word_ovf, fifo_full, drop_cnt);
      end
      @(negedge clock) reset = 1'b1;
      @(posedge clock); #1;
      checks++;
      if (word_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_release_valid got %0b required 0", word_valid);
      end
   endtask

   task automatic test_full_word;
      for (int i = 0; i < 7; i++) cyc(1'b1, (8'h4D >> i) & 8'h01, 1'b0, 1'b0, 1'b0);
      checks++;
      if (word_valid !== 1'b0) begin
         failures++;
         $display("FAIL full_word_early got valid=%0b required 0", word_valid);
      end
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (word_valid !== 1'b1 || word_data !== 8'h4D || word_len !== 4'd8 || word_ovf !== 1'b0) begin
         failures++;
         $display("FAIL full_word got v=%0b d=%h l=%0d o=%0b required v=1 d=4d l=8 o=0",
                  word_valid, word_data, word_len, word_ovf);
      end
   endtask

   task automatic test_overflow;
      send_word(8'h4D, 8'b0000_0100);
      send_word(8'hA5, 8'h00);
      checks++;
      if (word_data !== 8'h4D || word_ovf !== 1'b1) begin
         failures++;
         $display("FAIL overflow_tag got d=%h o=%0b required d=4d o=1", word_data, word_ovf);
      end
   endtask

   task automatic test_flush;
      repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (word_valid !== 1'b1 || word_data !== 8'h07 || word_len !== 4'd3) begin
         failures++;
         $display("FAIL flush_partial got v=%0b d=%h l=%0d required v=1 d=07 l=3",
                  word_valid, word_data, word_len);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic test_full_drop;
      send_word(8'h11, 8'h00);
      send_word(8'h22, 8'h00);
      send_word(8'h33, 8'h01);
      send_word(8'h44, 8'h00);
      checks++;
      if (fifo_full !== 1'b1 || drop_cnt !== 8'd0) begin
         failures++;
         $display("FAIL full_after_4 got full=%0b drop=%0d required full=1 drop=0", fifo_full, drop_cnt);
      end
      send_word(8'h55, 8'h00);
      checks++;
      if (fifo_full !== 1'b1 || drop_cnt !== 8'd1 || drop_cnt !== 8'(m_drop)) begin
         failures++;
         $display("FAIL drop_5th got full=%0b drop=%0d required full=1 drop=1", fifo_full, drop_cnt);
      end
   endtask

   task automatic test_full_simul;
      send_word(8'hA1, 8'h00);
      send_word(8'hA2, 8'h00);
      send_word(8'hA3, 8'h00);
      send_word(8'hA4, 8'h00);
      for (int i = 0; i < 7; i++) cyc(1'b1, (8'h5A >> i) & 8'h01, 1'b0, 1'b0, 1'b0);
      checks++;
      if (fifo_full !== 1'b1 || word_data !== 8'hA1) begin
         failures++;
         $display("FAIL simul_pre got full=%0b d=%h required full=1 d=a1", fifo_full, word_data);
      end
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (fifo_full !== 1'b1 || drop_cnt !== 8'd1 || word_data !== 8'hA2) begin
         failures++;
         $display("FAIL simul_push_pop got full=%0b drop=%0d d=%h required full=1 drop=1 d=a2",
                  fifo_full, drop_cnt, word_data);
      end
   endtask

   task automatic test_reset_mid;
      send_word(8'hC3, 8'h00);
      repeat (5) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({word_valid, word_data, word_len, word_ovf, fifo_full, drop_cnt} !== 23'd0) begin
         failures++;
         $display("FAIL reset_mid_async got v=%0b d=%h l=%0d o=%0b f=%0b drop=%0d required all 0",
                  word_valid, word_data, word_len, word_ovf, fifo_full, drop_cnt);
      end
      q.delete(); m_sh = '0; m_bc = 0; m_ov = 1'b0; m_drop = 0;
      @(negedge clock) reset = 1'b1;
      send_word(8'h96, 8'h00);
      checks++;
      if (word_valid !== 1'b1 || word_data !== 8'h96 || word_len !== 4'd8 || word_ovf !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_fresh got v=%0b d=%h l=%0d o=%0b required v=1 d=96 l=8 o=0",
                  word_valid, word_data, word_len, word_ovf);
      end
   endtask

   task automatic test_drain;
      int n = 0;
      ent_t e;
      while ((q.size() != 0 || word_valid) && n < 20) begin
         checks++;
         if (q.size() == 0) begin
            failures++;
            $display("FAIL drain_extra got d=%h l=%0d required no word", word_data, word_len);
         end else begin
            e = q[0];
            if (word_valid !== 1'b1 || word_data !== e.data || word_len !== e.len || word_ovf !== e.ovf) begin
               failures++;
               $display("FAIL drain_word got v=%0b d=%h l=%0d o=%0b required v=1 d=%h l=%0d o=%0b",
                        word_valid, word_data, word_len, word_ovf, e.data, e.len, e.ovf);
            end
`ifdef B01_COLLECT_PARITY_EN
            checks++;
            if (word_par !== ^e.data) begin
               failures++;
               $display("FAIL drain_parity got %0b required %0b", word_par, ^e.data);
            end
`endif
         end
         cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         n++;
      end
      checks++;
      if (n >= 20 || word_valid !== 1'b0 || word_data !== 8'h00 || word_len !== 4'd0 || fifo_full !== 1'b0) begin
         failures++;
         $display("FAIL drain_empty got v=%0b d=%h l=%0d f=%0b cycles=%0d required empty",
                  word_valid, word_data, word_len, fifo_full, n);
      end
   endtask

   initial begin
      test_reset;
      test_full_word;
      test_drain;
      test_overflow;
      test_drain;
      test_flush;
      test_drain;
      test_full_drop;
      test_drain;
      test_full_simul;
      test_drain;
      test_reset_mid;
      test_drain;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
